// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: holds a 32-entry complex sample buffer and, on start, resets the
// streaming FFT core, streams one contiguous 32-sample frame into it, waits out the
// core's pipeline latency and pulses done. Optional conjugation of the imaginary part
// lets the forward core compute an inverse transform.
module fft_frame_feeder #(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        start,
  input  logic        conj,
  output logic        busy,
  output logic        done,
  output logic        wr_dropped,
  output logic        fft_reset,
  output logic        in_valid,
  output logic [11:0] din_r,
  output logic [11:0] din_i
);

  // One shared counter serves both FLUSH and DRAIN, sized for the longer of the two.
  localparam int unsigned CntMax = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] RstLast   = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StStream, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic            conj_q, conj_d;
  logic [23:0]     mem_q [32];

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_dropped_q, wr_dropped_d;
  logic            fft_reset_q, fft_reset_d;
  logic            in_valid_q, in_valid_d;
  logic [11:0]     din_r_q, din_r_d;
  logic [11:0]     din_i_q, din_i_d;

  logic            wr_accept;
  logic            start_accept;
  logic [23:0]     sample;
  logic [11:0]     im_neg;

  assign wr_accept    = wr_en && !busy_q;
  assign start_accept = (state_q == StIdle) && start;

  // Sample buffer: deliberately not reset so contents survive a mid-frame reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state logic for frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    conj_d  = conj_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFlush;
          cnt_d   = '0;
          conj_d  = conj;
        end
      end
      StFlush: begin
        if (cnt_q == RstLast) begin
          state_d = StStream;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStream: begin
        // Index wraps 31 -> 0 naturally on the final sample.
        idx_d = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    sample       = mem_q[idx_d];
    // -(-2048) does not fit in 12 bits; saturate to +2047.
    im_neg       = (sample[11:0] == 12'h800) ? 12'h7ff : (~sample[11:0] + 12'd1);
    busy_d       = (state_d != StIdle);
    fft_reset_d  = (state_d == StFlush);
    in_valid_d   = (state_d == StStream);
    done_d       = (state_d == StDrain) && (cnt_d == DrainLast);
    din_r_d      = 12'd0;
    din_i_d      = 12'd0;
    if (state_d == StStream) begin
      din_r_d = sample[23:12];
      din_i_d = conj_d ? im_neg : sample[11:0];
    end
    wr_dropped_d = wr_dropped_q;
    if (start_accept) begin
      wr_dropped_d = 1'b0;
    end else if (wr_en && busy_q) begin
      wr_dropped_d = 1'b1;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      conj_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_dropped_q <= 1'b0;
      fft_reset_q  <= 1'b0;
      in_valid_q   <= 1'b0;
      din_r_q      <= 12'd0;
      din_i_q      <= 12'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      conj_q       <= conj_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wr_dropped_q <= wr_dropped_d;
      fft_reset_q  <= fft_reset_d;
      in_valid_q   <= in_valid_d;
      din_r_q      <= din_r_d;
      din_i_q      <= din_i_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_dropped = wr_dropped_q;
  assign fft_reset  = fft_reset_q;
  assign in_valid   = in_valid_q;
  assign din_r      = din_r_q;
  assign din_i      = din_i_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed testbench for fft_frame_feeder with default parameters.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic        conj = 1'b0;
  logic        busy, done, wr_dropped, fft_reset, in_valid;
  logic [11:0] din_r, din_i;

  fft_frame_feeder #(
    .RST_CYCLES  (2),
    .DRAIN_CYCLES(40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .conj      (conj),
    .busy      (busy),
    .done      (done),
    .wr_dropped(wr_dropped),
    .fft_reset (fft_reset),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [32];
  logic [11:0] cap_r [64];
  logic [11:0] cap_i [64];
  int n_valid, rst_first, rst_cnt, valid_first, valid_last;
  int done_cycle, done_count, busy_low, busy_at1, wd_at1, nz_out;
  int inval_after, busy_after;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] neg12(input logic [11:0] v);
    return (v == 12'h800) ? 12'h7ff : (12'd0 - v);
  endfunction

  task automatic write(input logic [4:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mem[a]  = d;
  endtask

  // Pulses start and watches 120 cycles; cycle c = c-th cycle after the start edge.
  // inj_kind 1: write entry 20 plus a start at cycle inj_c; 2: reset at cycle inj_c.
  task automatic run_frame(input logic cj, input int inj_kind, input int inj_c,
                           input logic do_wr, input logic [4:0] wa, input logic [23:0] wd);
    n_valid = 0; rst_first = -1; rst_cnt = 0; valid_first = -1; valid_last = -1;
    done_cycle = -1; done_count = 0; busy_low = -1; busy_at1 = -1; wd_at1 = -1;
    nz_out = 0; inval_after = -1; busy_after = -1;
    start = 1'b1;
    conj  = cj;
    if (do_wr) begin
      wr_en   = 1'b1;
      wr_addr = wa;
      wr_data = wd;
      mem[wa] = wd;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      if (c == 1) begin
        busy_at1 = busy;
        wd_at1   = wr_dropped;
      end
      if (fft_reset) begin
        if (rst_first < 0) rst_first = c;
        rst_cnt++;
      end
      if (in_valid) begin
        if (valid_first < 0) valid_first = c;
        valid_last = c;
        if (n_valid < 64) begin
          cap_r[n_valid] = din_r;
          cap_i[n_valid] = din_i;
        end
        n_valid++;
      end else if (din_r != 12'd0 || din_i != 12'd0) begin
        nz_out++;
      end
      if (done) begin
        done_count++;
        done_cycle = c;
      end
      if (!busy && busy_low < 0) busy_low = c;
      if (c == inj_c + 1) begin
        inval_after = in_valid;
        busy_after  = busy;
      end
      if (c == inj_c && inj_kind == 1) begin
        wr_en   = 1'b1;
        wr_addr = 5'd20;
        wr_data = {12'd1, 12'd1};
        start   = 1'b1;
        conj    = 1'b1;
      end else if (c == inj_c && inj_kind == 2) begin
        reset = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      reset = 1'b0;
    end
  endtask

  task automatic check_timing(input string tag);
    chk({tag, "_busy_rise"}, busy_at1, 1);
    chk({tag, "_rst_first"}, rst_first, 1);
    chk({tag, "_rst_len"}, rst_cnt, 2);
    chk({tag, "_valid_first"}, valid_first, 3);
    chk({tag, "_valid_last"}, valid_last, 34);
    chk({tag, "_n_valid"}, n_valid, 32);
    chk({tag, "_done_cycle"}, done_cycle, 74);
    chk({tag, "_done_count"}, done_count, 1);
    chk({tag, "_busy_low"}, busy_low, 75);
    chk({tag, "_idle_data"}, nz_out, 0);
  endtask

  task automatic check_samples(input logic cj, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_s%0d", tag, k), {8'd0, cap_r[k], cap_i[k]},
          {8'd0, mem[k][23:12], (cj ? neg12(mem[k][11:0]) : mem[k][11:0])});
    end
  endtask

  initial begin
    int act;
    logic [11:0] kv;

    // Reset then idle
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_dropped", wr_dropped, 0);
    chk("rst_fft_reset", fft_reset, 0);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_din", {din_r, din_i}, 0);
    act = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy || done || wr_dropped || fft_reset || in_valid || din_r != 0 || din_i != 0)
        act++;
      tick();
    end
    chk("idle_activity", act, 0);

    // Basic frame: entry k = {k, -k}
    for (int k = 0; k < 32; k++) begin
      kv = 12'(k);
      write(5'(k), {kv, 12'd0 - kv});
    end
    run_frame(1'b0, 0, -5, 1'b0, 5'd0, 24'd0);
    check_timing("basic");
    chk("basic_s0", {cap_r[0], cap_i[0]}, 24'h000000);
    chk("basic_s5", {cap_r[5], cap_i[5]}, 24'h005ffb);
    chk("basic_s31", {cap_r[31], cap_i[31]}, 24'h01ffe1);
    check_samples(1'b0, 32, "basic");

    // Conjugate and saturation
    write(5'd0, {12'd5, 12'd7});
    write(5'd1, {12'hffd, 12'h800});
    write(5'd2, {12'd0, 12'h7ff});
    run_frame(1'b1, 0, -5, 1'b0, 5'd0, 24'd0);
    check_timing("conj");
    chk("conj_s0", {cap_r[0], cap_i[0]}, 24'h005ff9);
    chk("conj_s1", {cap_r[1], cap_i[1]}, 24'hffd7ff);
    chk("conj_s2", {cap_r[2], cap_i[2]}, 24'h000801);
    chk("conj_s3", {cap_r[3], cap_i[3]}, 24'h003003);
    check_samples(1'b1, 32, "conj");

    // Write and start while streaming are ignored
    run_frame(1'b0, 1, 10, 1'b0, 5'd0, 24'd0);
    check_timing("busy");
    chk("busy_s20", {cap_r[20], cap_i[20]}, 24'h014fec);
    chk("busy_wr_dropped", wr_dropped, 1);
    check_samples(1'b0, 32, "busy");

    // Start with simultaneous write; also clears wr_dropped
    run_frame(1'b0, 0, -5, 1'b1, 5'd0, {12'd9, 12'd9});
    check_timing("simul");
    chk("simul_wd_cleared", wd_at1, 0);
    chk("simul_s0", {cap_r[0], cap_i[0]}, 24'h009009);
    check_samples(1'b0, 32, "simul");

    // Reset while sample 10 is on the bus (cycle 13)
    run_frame(1'b0, 2, 13, 1'b0, 5'd0, 24'd0);
    chk("rstmid_valid_at10", {cap_r[10], cap_i[10]}, 24'h00aff6);
    chk("rstmid_in_valid", inval_after, 0);
    chk("rstmid_busy", busy_after, 0);
    chk("rstmid_n_valid", n_valid, 11);
    chk("rstmid_done_count", done_count, 0);
    chk("rstmid_busy_low", busy_low, 14);
    run_frame(1'b0, 0, -5, 1'b0, 5'd0, 24'd0);
    check_timing("after");
    chk("after_s0", {cap_r[0], cap_i[0]}, 24'h009009);
    check_samples(1'b0, 32, "after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
